data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the core's load/store port; the core's LSU is the initiator.
- Implements word-addressed RAM with byte-lane writes, programmable wait states, pipelined read data and an out-of-range error flag.
- Sits between the core's data port and the top-level; also used as instruction/data backing store in core benches.

Parameters:
- DEPTH, 1024, number of 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_STATES, 0, cycles waitrequest is held per accepted request (0..15).
- ERR_DATA, 32'hDEAD_BEEF, readdata returned for out-of-range reads.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- address  in  32  byte address; bits [1:0] ignored.
- read  in  1  read request, held until accepted.
- write  in  1  write request, held until accepted.
- writedata  in  32  store data, lane-aligned (Types::word).
- byteenable  in  4  lane mask, bit i = bits [8i+7:8i].
- waitrequest  out  1  high = request not yet accepted.
- readdata  out  32  load data, valid with readdatavalid.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- error  out  1  one-cycle pulse: out-of-range access or read&write together.

Behaviour:
- One clock; reset synchronous active-high. Reset: state IDLE, counter 0, waitrequest 0, readdatavalid 0, readdata 0, error 0. RAM contents not cleared.
- FSM states: IDLE, STALL, ACCEPT.
- IDLE: (read|write)=1 with WAIT_STATES=0 -> accepted this cycle, waitrequest stays 0, stay IDLE. With WAIT_STATES>0 -> waitrequest 1 combinationally, counter loads WAIT_STATES-1, go STALL.
- STALL: waitrequest 1; decrement counter; at 0 go ACCEPT.
- ACCEPT: waitrequest 0; request accepted this cycle; go IDLE.
- Request arriving at cycle t is therefore accepted at cycle t+WAIT_STATES.
- If read and write both drop during STALL (initiator violation): return to IDLE, no commit, no pulse.
- Write accept: RAM lanes with byteenable=1 updated at the accept edge; byteenable=0 is a legal no-op.
- Read accept: RAM word registered at the accept edge; readdata/readdatavalid valid the following cycle. Read latency = WAIT_STATES+1.
- readdata holds its last value when readdatavalid=0.
- Index = (address-BASE_ADDR)>>2. Out of range (address<BASE_ADDR or index>=DEPTH):
  - write: dropped, error pulse with accept.
  - read: readdata=ERR_DATA, readdatavalid and error both pulse.
- read&write together: write executes, read ignored, error pulses at accept.
- Back-to-back: a new request may be presented the cycle after accept. Read-after-write to the same address returns the new data, no hazard (write committed before the read samples).
- Reset during STALL/ACCEPT: aborts, nothing committed; a read data pulse scheduled for the next cycle is suppressed.

Decomposition:
- Types package gains: enum mem_resp_state_t {MR_IDLE, MR_STALL, MR_ACCEPT}; typedef bit [3:0] byte_en_t; localparam word MEM_ERR_DATA = 32'hDEAD_BEEF.
- Sub-module ram_1rw_be: single-port synchronous RAM, DEPTH x 32, 4-lane byte write enable, registered read. The FSM, range check and error logic live in data_mem_responder.

Test Plan:
- WAIT_STATES=0: write 32'h1234_5678 @0x10, be=4'hF; read @0x10 next cycle -> waitrequest never 1, readdatavalid one cycle later, readdata=32'h1234_5678.
- WAIT_STATES=3: read @0x0 -> waitrequest high exactly 3 cycles, readdatavalid at t+4, single pulse.
- Byte lanes: preload 32'hFFFF_FFFF @0x20, write 32'h0000_AB00 be=4'b0010 -> read gives 32'hFFFF_ABFF.
- DEPTH=1024: read @0x1000 -> readdata=32'hDEAD_BEEF, error and readdatavalid pulse together; write @0x1000 -> error pulse, RAM unchanged.
- read&write both high @0x8, wdata 32'h5 -> error pulse; subsequent read @0x8 returns 32'h5.
- WAIT_STATES=2: rst asserted during STALL of a write @0x4 -> waitrequest 0, no readdatavalid, @0x4 keeps its old value.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared types for the data memory responder
package data_mem_responder_pkg;

  typedef logic [31:0] word;
  typedef bit [3:0] byte_en_t;

  typedef enum logic [1:0] {
    MR_IDLE,
    MR_STALL,
    MR_ACCEPT
  } mem_resp_state_t;

  localparam word MEM_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/data_mem_responder_ram_1rw_be.sv
// rtl/data_mem_responder_ram_1rw_be.sv - single-port RAM, byte-lane writes, registered read
module ram_1rw_be
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  byte_en_t      be,
  input  logic [AW-1:0] addr,
  input  word           wdata,
  output word           rdata
);

  word mem [DEPTH];

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - LSU-facing RAM responder with wait states and range errors
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter word         ERR_DATA    = MEM_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        error
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WS = 4'(WAIT_STATES);

  mem_resp_state_t state;
  logic [3:0]      cnt;
  logic            err_sel;
  word             ram_rdata;

  logic        req;
  logic [29:0] word_off;
  logic        in_range;
  logic        accept;
  logic        ram_we;
  logic        ram_re;

  assign req      = read | write;
  assign word_off = address[31:2] - BASE_ADDR[31:2];
  assign in_range = (address >= BASE_ADDR) && ({2'b00, word_off} < 32'(DEPTH));
  assign accept   = req && (((state == MR_IDLE) && (WS == 4'd0)) || (state == MR_ACCEPT));

  assign waitrequest = (state == MR_STALL) || ((state == MR_IDLE) && req && (WS != 4'd0));

  // A simultaneous read+write performs only the write.
  assign ram_we = accept && write && in_range && !rst;
  assign ram_re = accept && read && !write && in_range && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= MR_IDLE;
      cnt           <= '0;
      readdatavalid <= 1'b0;
      error         <= 1'b0;
      err_sel       <= 1'b0;
    end else begin
      readdatavalid <= accept && read && !write;
      error         <= accept && (!in_range || (read && write));
      if (accept && read && !write) err_sel <= !in_range;

      case (state)
        MR_IDLE: begin
          if (req && (WS != 4'd0)) begin
            if (WS == 4'd1) begin
              state <= MR_ACCEPT;
            end else begin
              state <= MR_STALL;
              cnt   <= WS - 4'd1;
            end
          end
        end
        MR_STALL: begin
          // An initiator that drops its request mid-stall gets nothing.
          if (!req) begin
            state <= MR_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= MR_ACCEPT;
          end
        end
        MR_ACCEPT: state <= MR_IDLE;
        default:   state <= MR_IDLE;
      endcase
    end
  end

  assign readdata = err_sel ? ERR_DATA : ram_rdata;

  ram_1rw_be #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .be    (byteenable),
    .addr  (word_off[AW-1:0]),
    .wdata (writedata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - bench for data_mem_responder at 0, 2 and 3 wait states
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        rd   [3];
  logic        wr   [3];
  logic        wq   [3];
  logic        rdv  [3];
  logic        er   [3];
  logic [31:0] rdat [3];

  logic [31:0] mdl     [3][1024];
  logic [31:0] last_rd [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .WAIT_STATES ((g == 0) ? 0 : g + 1)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .address       (address),
      .read          (rd[g]),
      .write         (wr[g]),
      .writedata     (writedata),
      .byteenable    (byteenable),
      .waitrequest   (wq[g]),
      .readdata      (rdat[g]),
      .readdatavalid (rdv[g]),
      .error         (er[g])
    );
  end

  function automatic int ws(int i);
    return (i == 0) ? 0 : i + 1;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(int i, bit r, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] be);
    bit          inr;
    int          idx;
    bit          exp_rv;
    bit          exp_er;
    logic [31:0] exp_d;
    int          n;
    inr    = (a >> 2) < 1024;
    idx    = int'(a[11:2]);
    exp_rv = r && !w;
    exp_er = !inr || (r && w);
    exp_d  = exp_rv ? (inr ? mdl[i][idx] : 32'hDEAD_BEEF) : last_rd[i];
    address = a; writedata = d; byteenable = be; rd[i] = r; wr[i] = w;
    #1;
    n = 0;
    while (wq[i] && n < 40) begin
      @(negedge clk);
      n++;
      check("quiet_while_waiting", {30'b0, rdv[i], er[i]}, 32'd0);
    end
    check("wait_cycles", 32'(n), 32'(ws(i)));
    @(negedge clk);
    rd[i] = 1'b0; wr[i] = 1'b0;
    check("readdatavalid", {31'b0, rdv[i]}, {31'b0, exp_rv});
    check("error", {31'b0, er[i]}, {31'b0, exp_er});
    check("readdata", rdat[i], exp_d);
    if (w && inr)
      for (int b = 0; b < 4; b++)
        if (be[b]) mdl[i][idx][8*b +: 8] = d[8*b +: 8];
    last_rd[i] = exp_d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; address = '0; writedata = '0; byteenable = '0;
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; last_rd[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("reset_waitrequest", {31'b0, wq[i]}, 32'd0);
      check("reset_readdatavalid", {31'b0, rdv[i]}, 32'd0);
      check("reset_error", {31'b0, er[i]}, 32'd0);
      check("reset_readdata", rdat[i], 32'd0);
    end

    // zero wait states, back-to-back write then read
    issue(0, 0, 1, 32'h10, 32'h1234_5678, 4'hF);
    issue(0, 1, 0, 32'h10, 32'h0, 4'hF);

    // three wait states: latency 4, single pulse
    issue(2, 0, 1, 32'h0, 32'h0BAD_F00D, 4'hF);
    issue(2, 1, 0, 32'h0, 32'h0, 4'hF);
    @(negedge clk);
    check("single_pulse", {31'b0, rdv[2]}, 32'd0);

    // byte lanes, including an all-zero lane mask
    issue(0, 0, 1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    issue(0, 0, 1, 32'h20, 32'h0000_AB00, 4'b0010);
    issue(0, 1, 0, 32'h20, 32'h0, 4'hF);
    issue(0, 0, 1, 32'h20, 32'h1234_5678, 4'b0000);
    issue(0, 1, 0, 32'h20, 32'h0, 4'hF);

    // out-of-range read and write; word 0 must not be aliased
    issue(0, 0, 1, 32'h0, 32'hCAFE_0000, 4'hF);
    issue(0, 1, 0, 32'h1000, 32'h0, 4'hF);
    issue(0, 0, 1, 32'h1000, 32'h0000_0001, 4'hF);
    issue(0, 1, 0, 32'h0, 32'h0, 4'hF);

    // read and write together
    issue(0, 1, 1, 32'h8, 32'h5, 4'hF);
    issue(0, 1, 0, 32'h8, 32'h0, 4'hF);

    // reset during a stalled write
    issue(1, 0, 1, 32'h4, 32'h1111_2222, 4'hF);
    address = 32'h4; writedata = 32'hAAAA_5555; byteenable = 4'hF; wr[1] = 1'b1;
    #1;
    check("stall_waitrequest", {31'b0, wq[1]}, 32'd1);
    @(negedge clk);
    check("stall_waitrequest_2", {31'b0, wq[1]}, 32'd1);
    rst = 1'b1; wr[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_waitrequest", {31'b0, wq[1]}, 32'd0);
    check("post_reset_readdatavalid", {31'b0, rdv[1]}, 32'd0);
    check("post_reset_error", {31'b0, er[1]}, 32'd0);
    for (int i = 0; i < 3; i++) last_rd[i] = '0;
    @(negedge clk);
    check("post_reset_no_pulse", {31'b0, rdv[1]}, 32'd0);
    issue(1, 1, 0, 32'h4, 32'h0, 4'hF);

    // randomized traffic on every configuration
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 16; w++) issue(i, 0, 1, 32'(w * 4), $urandom, 4'hF);
      for (int k = 0; k < 60; k++) begin
        int          sel;
        int          op;
        logic [31:0] a;
        sel = $urandom_range(0, 9);
        if (sel == 0)      a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
        else if (sel == 1) a = 32'hFFFF_FFFC;
        else               a = 32'($urandom_range(0, 15) * 4);
        op = $urandom_range(0, 5);
        issue(i, (op < 2) || (op >= 4), (op >= 2) && (op <= 4), a, $urandom,
              4'($urandom_range(0, 15)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
